// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light timing blocks.
//   DEF_DIV_W   : default prescaler divisor width
//   DEF_DIV     : divisor loaded at reset (clock cycles per tick)
//   DEF_CNT_W   : default phase timer width
//   tmr_state_t : phase timer states
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_DIV   = 6;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Runtime-programmable clock divider. Emits a one-cycle tick every div_reg
// enabled cycles and a square wave sq that toggles on every tick.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   en         in   count enable; low freezes pcnt and sq
//   div_load   in   capture div_value into div_reg (ignored when zero)
//   div_value  in   new divisor, clock cycles per tick
//   restart    in   clear pcnt this cycle (valid divisor or timer load)
//   tick       out  registered one-cycle pulse
//   sq         out  registered square wave, period 2 x divisor
//   tick_next  out  combinational: tick will be set on this edge
// ---------------------------------------------------------------------------
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             restart,
  output logic             tick,
  output logic             sq,
  output logic             tick_next
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] pcnt;
  logic             div_ok;
  logic             at_terminal;

  // A zero divisor would leave the counter without a terminal value, so it
  // is simply not accepted.
  assign div_ok      = div_load && (div_value != '0);
  assign at_terminal = (pcnt == div_reg - DIV_W'(1));

  // The timer must decrement exactly on the edges that raise tick, so this
  // mirrors the tick branch below, including suppression by restart.
  assign tick_next = en && at_terminal && !restart;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg <= DIV_W'(DEFAULT_DIV);
      pcnt    <= '0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (div_ok) begin
        div_reg <= div_value;
      end
      // Restart wins over counting and is honoured even while disabled,
      // so the first tick after any load is a full period away.
      if (restart) begin
        pcnt <= '0;
        tick <= 1'b0;
      end else if (en) begin
        if (at_terminal) begin
          pcnt <= '0;
          tick <= 1'b1;
          sq   <= ~sq;
        end else begin
          pcnt <= pcnt + DIV_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/second_timer.sv
// ---------------------------------------------------------------------------
// second_timer
// Programmable second generator plus loadable down-counting phase timer for
// the traffic-light sequencer. The timer counts prescaler ticks and pulses
// tmr_done for one cycle when the loaded duration has elapsed.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   en             in   enable; low freezes prescaler and timer
//   div_load       in   load div_value as the new divisor
//   div_value      in   divisor in clock cycles per tick (zero ignored)
//   tmr_load       in   start/restart the timer with tmr_value
//   tmr_value      in   timer duration in ticks (zero ignored)
//   tick           out  one-cycle pulse every divisor enabled cycles
//   sq             out  square wave toggling on every tick
//   tmr_busy       out  timer running
//   tmr_remaining  out  ticks left
//   tmr_done       out  one-cycle expiry pulse
// ---------------------------------------------------------------------------
module second_timer
  import traffic_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             tmr_load,
  input  logic [CNT_W-1:0] tmr_value,
  output logic             tick,
  output logic             sq,
  output logic             tmr_busy,
  output logic [CNT_W-1:0] tmr_remaining,
  output logic             tmr_done
);

  tmr_state_t state;
  logic       tmr_start;
  logic       restart;
  logic       tick_next;

  assign tmr_start = tmr_load && (tmr_value != '0);

  // Both a new divisor and a new timer duration realign the prescaler;
  // when they coincide the counter is still cleared just once.
  assign restart = (div_load && (div_value != '0)) || tmr_start;

  tick_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .restart   (restart),
    .tick      (tick),
    .sq        (sq),
    .tick_next (tick_next)
  );

  // The state register is the busy flag, so busy rises on the loading edge
  // and falls on the same edge that raises tmr_done.
  assign tmr_busy = (state == RUN);

  // In RUN the remaining count is always at least 1, so expiry is detected
  // at 1 and the counter can never wrap below zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tmr_remaining <= '0;
      tmr_done      <= 1'b0;
    end else begin
      tmr_done <= 1'b0;
      if (tmr_start) begin
        state         <= RUN;
        tmr_remaining <= tmr_value;
      end else begin
        case (state)
          RUN: begin
            if (tick_next) begin
              if (tmr_remaining == CNT_W'(1)) begin
                tmr_remaining <= '0;
                tmr_done      <= 1'b1;
                state         <= IDLE;
              end else begin
                tmr_remaining <= tmr_remaining - CNT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_second_timer.sv
// ---------------------------------------------------------------------------
// tb_second_timer
// Scoreboarded bench for second_timer. The driver predicts each cycle's
// outputs from a tick/elapsed-count model and queues them; a monitor pops
// and compares on the falling edge, or immediately on a reset probe.
// ---------------------------------------------------------------------------
module tb_second_timer;

  localparam int DIV_W       = 16;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             tmr_load = 1'b0;
  logic [CNT_W-1:0] tmr_value = '0;
  logic             tick;
  logic             sq;
  logic             tmr_busy;
  logic [CNT_W-1:0] tmr_remaining;
  logic             tmr_done;
  logic             probe = 1'b0;

  second_timer #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .div_load      (div_load),
    .div_value     (div_value),
    .tmr_load      (tmr_load),
    .tmr_value     (tmr_value),
    .tick          (tick),
    .sq            (sq),
    .tmr_busy      (tmr_busy),
    .tmr_remaining (tmr_remaining),
    .tmr_done      (tmr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             tick;
    logic             sq;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rem;
    int               phase;
    int               idx;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cur_phase   = 0;
  int   step_idx    = 0;

  // Reference model: ticks happen whenever the enabled-cycle count since the
  // last restart is a multiple of the divisor; the timer expires once the
  // number of ticks since its load equals the loaded duration.
  int m_div;
  int m_elapsed;
  int m_ticks;
  int m_load_ticks;
  int m_n;
  bit m_running;
  bit m_tick;
  bit m_done;

  function automatic string phaseName(input int p);
    case (p)
      0: return "reset";
      1: return "idle_ticks";
      2: return "div_load";
      3: return "timer_run";
      4: return "en_stall";
      5: return "reload";
      6: return "random";
      default: return "post_reset";
    endcase
  endfunction

  task automatic modelReset();
    m_div        = DEFAULT_DIV;
    m_elapsed    = 0;
    m_ticks      = 0;
    m_load_ticks = 0;
    m_n          = 0;
    m_running    = 1'b0;
    m_tick       = 1'b0;
    m_done       = 1'b0;
  endtask

  task automatic modelStep(input bit e, input bit dl, input int dv, input bit tl, input int tv);
    bit dl_ok;
    bit tl_ok;
    dl_ok = dl && (dv != 0);
    tl_ok = tl && (tv != 0);
    if (dl_ok) m_div = dv;
    if (dl_ok || tl_ok) begin
      m_elapsed = 0;
      m_tick    = 1'b0;
    end else if (e) begin
      m_elapsed = m_elapsed + 1;
      m_tick    = ((m_elapsed % m_div) == 0);
    end else begin
      m_tick = 1'b0;
    end
    if (m_tick) m_ticks = m_ticks + 1;
    m_done = 1'b0;
    if (tl_ok) begin
      m_running    = 1'b1;
      m_n          = tv;
      m_load_ticks = m_ticks;
    end else if (m_running && m_tick && (m_ticks - m_load_ticks == m_n)) begin
      m_running = 1'b0;
      m_done    = 1'b1;
    end
  endtask

  function automatic exp_t makeExp();
    exp_t x;
    x.tick  = m_tick;
    x.sq    = ((m_ticks % 2) == 1);
    x.busy  = m_running;
    x.done  = m_done;
    x.rem   = m_running ? CNT_W'(m_n - (m_ticks - m_load_ticks)) : '0;
    x.phase = cur_phase;
    x.idx   = step_idx;
    return x;
  endfunction

  // Inputs are driven between edges; the prediction is queued right after
  // the edge that samples them and checked on the following falling edge.
  task automatic applyStimulus(input bit e, input bit dl, input int dv, input bit tl, input int tv);
    exp_t x;
    en        = e;
    div_load  = dl;
    div_value = DIV_W'(dv);
    tmr_load  = tl;
    tmr_value = CNT_W'(tv);
    modelStep(e, dl, dv, tl, tv);
    x = makeExp();
    step_idx++;
    @(posedge clk);
    sb.push_back(x);
    #1;
  endtask

  task automatic runIdle(input int n, input bit e);
    for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 0, 1'b0, 0);
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic resetProbe();
    @(negedge clk);
    #1;
    en       = 1'b0;
    div_load = 1'b0;
    tmr_load = 1'b0;
    reset    = 1'b0;
    #1;
    modelReset();
    cur_phase = 0;
    sb.push_back(makeExp());
    probe = 1'b1;
    #1;
    probe = 1'b0;
  endtask

  task automatic releaseReset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic checkOutput(input exp_t x);
    vectors++;
    if (tick !== x.tick || sq !== x.sq || tmr_busy !== x.busy ||
        tmr_done !== x.done || tmr_remaining !== x.rem) begin
      miscompares++;
      $display("[TB] FAIL %s step %0d @%0t: got tick=%b sq=%b busy=%b done=%b rem=%0d, expected tick=%b sq=%b busy=%b done=%b rem=%0d",
               phaseName(x.phase), x.idx, $time, tick, sq, tmr_busy, tmr_done, tmr_remaining,
               x.tick, x.sq, x.busy, x.done, x.rem);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge probe);
      while (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    modelReset();
    resetProbe();
    releaseReset();

    // Default divisor: ticks after edges 6, 12, 18.
    cur_phase = 1;
    runIdle(20, 1'b1);

    // New divisor 3, then a zero divisor that must be ignored.
    cur_phase = 2;
    applyStimulus(1'b1, 1'b1, 3, 1'b0, 0);
    runIdle(10, 1'b1);
    applyStimulus(1'b1, 1'b1, 0, 1'b0, 0);
    runIdle(10, 1'b1);

    // Back to D=6, three-tick phase runs to expiry.
    cur_phase = 3;
    applyStimulus(1'b1, 1'b1, 6, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 3);
    runIdle(25, 1'b1);

    // Ten-cycle enable stall in the middle of a run.
    cur_phase = 4;
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 3);
    runIdle(8, 1'b1);
    runIdle(10, 1'b0);
    runIdle(15, 1'b1);

    // Reload with 5 on the terminal edge where remaining would hit 0.
    cur_phase = 5;
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 2);
    runIdle(11, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 5);
    runIdle(35, 1'b1);

    // Randomised traffic, including zero-valued and simultaneous loads.
    cur_phase = 6;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 49) == 0, int'($urandom_range(0, 8)),
                    $urandom_range(0, 39) == 0, int'($urandom_range(0, 5)));
    end
    runIdle(50, 1'b1);

    // Reset mid-run with a non-default divisor; default must come back.
    cur_phase = 7;
    applyStimulus(1'b1, 1'b1, 3, 1'b1, 4);
    runIdle(5, 1'b1);
    resetProbe();
    releaseReset();
    cur_phase = 7;
    runIdle(20, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1);
    runIdle(8, 1'b1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
